// File: rtl/efuse_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : efuse_arb_mux
// Purpose  : Round-robin arbiter with session lock that shares one eFuse macro
//            among NCH RTL requesters. It has a register-mode override and a
//            grant watchdog. The macro is driven from one registered,
//            scan-gated control stage. Read data is returned only to the
//            current owner.
// Revision : 1.0 - initial parametrised NCH-channel release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                  block clock, async active-low reset
//   scan_mode                   forces every efuse_*_o to 0 (after the flops)
//   rg_efuse_reg_mode           software override of the macro controls
//   rg_efuse_pgmen/rden/aen     register-mode controls
//   rg_efuse_addr   [AW]        register-mode address
//   rg_efuse_rdata  [DW]        macro read data while in reg mode, else 0
//   ch_req          [NCH]       per-channel session request (held for session)
//   ch_gnt          [NCH]       one-hot grant
//   ch_pgmen/rden/aen [NCH]     per-channel controls
//   ch_addr         [NCH*AW]    per-channel address, channel i at [i*AW +: AW]
//   ch_rdata        [NCH*DW]    per-channel read data, only owner slice live
//   ch_tmo          [NCH]       one-cycle pulse on watchdog-revoked channel
//   efuse_pgmen_o/rden_o/aen_o  macro controls
//   efuse_addr_o    [AW]        macro address
//   efuse_rdata_i   [DW]        macro read data
// ============================================================================
module efuse_arb_mux #(
  parameter int NCH   = 4,
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int TMO   = 1024,
  parameter int TMO_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_mode,
  input  logic              rg_efuse_reg_mode,
  input  logic              rg_efuse_pgmen,
  input  logic              rg_efuse_rden,
  input  logic              rg_efuse_aen,
  input  logic [AW-1:0]     rg_efuse_addr,
  output logic [DW-1:0]     rg_efuse_rdata,
  input  logic [NCH-1:0]    ch_req,
  output logic [NCH-1:0]    ch_gnt,
  input  logic [NCH-1:0]    ch_pgmen,
  input  logic [NCH-1:0]    ch_rden,
  input  logic [NCH-1:0]    ch_aen,
  input  logic [NCH*AW-1:0] ch_addr,
  output logic [NCH*DW-1:0] ch_rdata,
  output logic [NCH-1:0]    ch_tmo,
  output logic              efuse_pgmen_o,
  output logic              efuse_rden_o,
  output logic              efuse_aen_o,
  output logic [AW-1:0]     efuse_addr_o,
  input  logic [DW-1:0]     efuse_rdata_i
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // The watchdog fires on the GRANT cycle in which the counter would reach
  // TMO, so a stuck owner holds the grant for exactly TMO cycles.
  localparam bit             WD_EN   = (TMO != 0);
  localparam logic [TMO_W-1:0] WD_LAST = WD_EN ? TMO_W'(TMO - 1) : '0;

  logic [1:0]       state, state_nxt;
  logic [NCH-1:0]   gnt, gnt_nxt;
  logic [NCH-1:0]   tmo, tmo_nxt;
  logic [NCH-1:0]   blocked, blk_set;
  logic [PW-1:0]    owner, owner_nxt;
  logic [PW-1:0]    rr_ptr, ptr_nxt;
  logic [PW-1:0]    owner_adv;
  logic [PW-1:0]    win;
  logic             found;
  logic [TMO_W-1:0] wd_cnt, wd_nxt;
  logic [NCH-1:0]   elig;
  logic             owner_drop;
  logic             wd_hit;
  logic             reg_mode;

  // Selected (pre-flop) controls and the registered output stage
  logic             sel_pgmen, sel_rden, sel_aen;
  logic [AW-1:0]    sel_addr;
  logic             q_pgmen, q_rden, q_aen;
  logic [AW-1:0]    q_addr;

  // Per-channel address unpacked so the owner mux indexes by channel number
  logic [AW-1:0]    addr_arr [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign addr_arr[gi] = ch_addr[gi*AW +: AW];
      // Only the granted slice carries macro data, and never in reg mode
      assign ch_rdata[gi*DW +: DW] = (gnt[gi] && !reg_mode) ? efuse_rdata_i : '0;
    end
  endgenerate

  assign reg_mode   = rg_efuse_reg_mode;
  assign elig       = ch_req & ~blocked;
  assign owner_drop = ~ch_req[owner];
  assign wd_hit     = WD_EN && (wd_cnt == WD_LAST);
  assign owner_adv  = (owner == PW'(NCH - 1)) ? '0 : owner + PW'(1);

  // Round-robin search: first eligible channel at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = rr_ptr;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (!found && elig[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // Priority in GRANT: reg mode, then owner release, then watchdog. A release
  // on the timeout cycle is therefore an ordinary release.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!reg_mode && found) begin
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (reg_mode || owner_drop || wd_hit) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = rr_ptr;
    wd_nxt    = wd_cnt;
    tmo_nxt   = '0;
    blk_set   = '0;
    case (state)
      ST_IDLE: begin
        gnt_nxt = '0;
        if (!reg_mode && found) begin
          gnt_nxt   = NCH'(1) << win;
          owner_nxt = win;
          wd_nxt    = '0;
        end
      end
      ST_GRANT: begin
        if (reg_mode) begin
          // Software takes the macro: silent revoke, pointer untouched
          gnt_nxt = '0;
        end else if (owner_drop) begin
          gnt_nxt = '0;
          ptr_nxt = owner_adv;
        end else if (wd_hit) begin
          gnt_nxt        = '0;
          tmo_nxt[owner] = 1'b1;
          blk_set[owner] = 1'b1;
          ptr_nxt        = owner_adv;
        end else if (WD_EN) begin
          wd_nxt = wd_cnt + TMO_W'(1);
        end
      end
      default: begin
        gnt_nxt = '0;
      end
    endcase
  end

  // Control selection ahead of the output flops. Outside GRANT (and reg mode)
  // everything is zero, which gives the macro a deselect cycle during GAP.
  always_comb begin
    sel_pgmen = 1'b0;
    sel_rden  = 1'b0;
    sel_aen   = 1'b0;
    sel_addr  = '0;
    if (reg_mode) begin
      sel_pgmen = rg_efuse_pgmen;
      sel_rden  = rg_efuse_rden;
      sel_aen   = rg_efuse_aen;
      sel_addr  = rg_efuse_addr;
    end else if (state == ST_GRANT) begin
      sel_pgmen = ch_pgmen[owner];
      sel_rden  = ch_rden[owner];
      sel_aen   = ch_aen[owner];
      sel_addr  = addr_arr[owner];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      tmo     <= '0;
      blocked <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      wd_cnt  <= '0;
      q_pgmen <= 1'b0;
      q_rden  <= 1'b0;
      q_aen   <= 1'b0;
      q_addr  <= '0;
    end else begin
      gnt     <= gnt_nxt;
      tmo     <= tmo_nxt;
      // A block survives only while the channel keeps its request asserted
      blocked <= (blocked & ch_req) | blk_set;
      owner   <= owner_nxt;
      rr_ptr  <= ptr_nxt;
      wd_cnt  <= wd_nxt;
      // Flops keep updating in scan; only the outputs are gated
      q_pgmen <= sel_pgmen;
      q_rden  <= sel_rden;
      q_aen   <= sel_aen;
      q_addr  <= sel_addr;
    end
  end

  assign ch_gnt         = gnt;
  assign ch_tmo         = tmo;
  assign efuse_pgmen_o  = q_pgmen & ~scan_mode;
  assign efuse_rden_o   = q_rden  & ~scan_mode;
  assign efuse_aen_o    = q_aen   & ~scan_mode;
  assign efuse_addr_o   = scan_mode ? '0 : q_addr;
  assign rg_efuse_rdata = reg_mode ? efuse_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_efuse_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_efuse_arb_mux
// Purpose  : Directed self-checking bench for efuse_arb_mux (NCH=4, TMO=16).
//            Expected values are queued when stimulus is applied and popped
//            when the corresponding DUT output is sampled (on the negedge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_efuse_arb_mux;

  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;

  logic              clk;
  logic              rst_n;
  logic              scan_mode;
  logic              rg_efuse_reg_mode;
  logic              rg_efuse_pgmen;
  logic              rg_efuse_rden;
  logic              rg_efuse_aen;
  logic [AW-1:0]     rg_efuse_addr;
  logic [DW-1:0]     rg_efuse_rdata;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_gnt;
  logic [NCH-1:0]    ch_pgmen;
  logic [NCH-1:0]    ch_rden;
  logic [NCH-1:0]    ch_aen;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_rdata;
  logic [NCH-1:0]    ch_tmo;
  logic              efuse_pgmen_o;
  logic              efuse_rden_o;
  logic              efuse_aen_o;
  logic [AW-1:0]     efuse_addr_o;
  logic [DW-1:0]     efuse_rdata_i;

  efuse_arb_mux #(
    .NCH   (NCH),
    .AW    (AW),
    .DW    (DW),
    .TMO   (16),
    .TMO_W (5)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .scan_mode         (scan_mode),
    .rg_efuse_reg_mode (rg_efuse_reg_mode),
    .rg_efuse_pgmen    (rg_efuse_pgmen),
    .rg_efuse_rden     (rg_efuse_rden),
    .rg_efuse_aen      (rg_efuse_aen),
    .rg_efuse_addr     (rg_efuse_addr),
    .rg_efuse_rdata    (rg_efuse_rdata),
    .ch_req            (ch_req),
    .ch_gnt            (ch_gnt),
    .ch_pgmen          (ch_pgmen),
    .ch_rden           (ch_rden),
    .ch_aen            (ch_aen),
    .ch_addr           (ch_addr),
    .ch_rdata          (ch_rdata),
    .ch_tmo            (ch_tmo),
    .efuse_pgmen_o     (efuse_pgmen_o),
    .efuse_rden_o      (efuse_rden_o),
    .efuse_aen_o       (efuse_aen_o),
    .efuse_addr_o      (efuse_addr_o),
    .efuse_rdata_i     (efuse_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Macro-side controls packed as {pgmen, rden, aen, addr}
  function automatic logic [31:0] macro_vec();
    return 32'({efuse_pgmen_o, efuse_rden_o, efuse_aen_o, efuse_addr_o});
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    scan_mode         = 1'b0;
    rg_efuse_reg_mode = 1'b0;
    rg_efuse_pgmen    = 1'b0;
    rg_efuse_rden     = 1'b0;
    rg_efuse_aen      = 1'b0;
    rg_efuse_addr     = '0;
    ch_req            = '0;
    ch_pgmen          = '0;
    ch_rden           = '0;
    ch_aen            = '0;
    ch_addr           = '0;
    efuse_rdata_i     = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    expect_val("rst_gnt", 32'h0);   chk(32'(ch_gnt));
    expect_val("rst_tmo", 32'h0);   chk(32'(ch_tmo));
    expect_val("rst_macro", 32'h0); chk(macro_vec());
    rst_n = 1'b1;
    tick();

    // ---------------- round robin from rr_ptr=0 ----------------
    ch_req = 4'b1010;
    expect_val("rr_first_gnt", 32'h2);
    tick(); chk(32'(ch_gnt));
    ch_req = 4'b1000;                         // ch1 releases
    expect_val("rr_gap_gnt", 32'h0);
    tick(); chk(32'(ch_gnt));
    expect_val("rr_idle_gnt", 32'h0);
    tick(); chk(32'(ch_gnt));
    expect_val("rr_second_gnt", 32'h8);
    tick(); chk(32'(ch_gnt));
    efuse_rdata_i = 8'h77;
    #1;
    expect_val("rdata_ch3", 32'h7700_0000);
    chk(ch_rdata);
    ch_req = 4'b0000;
    tick();
    tick();

    // ---------------- ch2 read session + scan gating ----------------
    ch_req              = 4'b0100;
    ch_rden             = 4'b0100;
    ch_pgmen            = 4'b0100;
    ch_addr[2*AW +: AW] = 8'h5A;
    ch_addr[0 +: AW]    = 8'hEE;              // non-owner, must be ignored
    expect_val("ch2_gnt", 32'h4);
    expect_val("ch2_macro_lat", 32'h0);
    tick(); chk(32'(ch_gnt)); chk(macro_vec());
    expect_val("ch2_macro", 32'h65A);         // pgmen=1 rden=1 aen=0 addr=5A
    tick(); chk(macro_vec());
    efuse_rdata_i = 8'hC3;
    #1;
    expect_val("ch2_rdata", 32'h00C3_0000);
    expect_val("ch2_rg_rdata", 32'h0);
    chk(ch_rdata); chk(32'(rg_efuse_rdata));
    scan_mode = 1'b1;
    #1;
    expect_val("scan_macro", 32'h0);
    chk(macro_vec());
    scan_mode = 1'b0;
    #1;
    expect_val("scan_release_macro", 32'h65A);
    chk(macro_vec());
    ch_req   = '0;
    ch_rden  = '0;
    ch_pgmen = '0;
    tick();
    expect_val("gap_macro", 32'h0);
    tick(); chk(macro_vec());

    // ---------------- reg-mode override of ch3 ----------------
    ch_req = 4'b1000;
    expect_val("ch3_gnt", 32'h8);
    tick(); chk(32'(ch_gnt));
    rg_efuse_reg_mode = 1'b1;
    rg_efuse_aen      = 1'b1;
    rg_efuse_addr     = 8'h11;
    expect_val("reg_gnt", 32'h0);
    expect_val("reg_tmo", 32'h0);
    expect_val("reg_macro", 32'h111);         // aen=1 addr=11
    tick(); chk(32'(ch_gnt)); chk(32'(ch_tmo)); chk(macro_vec());
    efuse_rdata_i = 8'h5E;
    #1;
    expect_val("reg_rg_rdata", 32'h5E);
    expect_val("reg_ch_rdata", 32'h0);
    chk(32'(rg_efuse_rdata)); chk(ch_rdata);
    expect_val("reg_hold_gnt", 32'h0);
    tick(); chk(32'(ch_gnt));
    expect_val("reg_hold_gnt2", 32'h0);
    tick(); chk(32'(ch_gnt));
    rg_efuse_reg_mode = 1'b0;
    rg_efuse_aen      = 1'b0;
    rg_efuse_addr     = '0;
    expect_val("reg_exit_gnt", 32'h8);
    tick(); chk(32'(ch_gnt));
    ch_req = '0;
    tick();
    tick();

    // ---------------- watchdog on ch0 ----------------
    ch_req = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      expect_val("wd_hold_gnt", 32'h1);
      tick(); chk(32'(ch_gnt));
    end
    expect_val("wd_revoke_gnt", 32'h0);
    expect_val("wd_tmo_pulse", 32'h1);
    tick(); chk(32'(ch_gnt)); chk(32'(ch_tmo));
    expect_val("wd_tmo_clear", 32'h0);
    tick(); chk(32'(ch_tmo));
    for (int i = 0; i < 4; i++) begin
      expect_val("wd_blocked_gnt", 32'h0);
      tick(); chk(32'(ch_gnt));
    end
    ch_req = '0;
    tick();
    ch_req = 4'b0001;
    expect_val("wd_regrant", 32'h1);
    tick(); chk(32'(ch_gnt));

    // ---------------- async reset mid-programming ----------------
    ch_pgmen = 4'b0001;
    expect_val("pre_rst_pgmen", 32'h1);
    tick(); chk(32'(efuse_pgmen_o));
    #1;
    rst_n = 1'b0;
    #1;
    expect_val("async_rst_pgmen", 32'h0);
    expect_val("async_rst_gnt", 32'h0);
    chk(32'(efuse_pgmen_o)); chk(32'(ch_gnt));
    tick();
    ch_pgmen = '0;
    ch_req   = 4'b1001;                       // rr_ptr was 1 before reset
    rst_n    = 1'b1;
    expect_val("post_rst_gnt", 32'h1);
    tick(); chk(32'(ch_gnt));
    ch_req = '0;
    tick();

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
